// File: rtl/seg7_hex_writer_if.sv
// ============================================================================
// seg7_hex_writer_if
// Request handshake plus Avalon-MM write bus of the seven-segment hex writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seg7_hex_writer_if #(
    parameter int SEG7_NUM   = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEG7_NUM*4-1:0]   in_value;
    logic [SEG7_NUM-1:0]     in_dp;
    logic [ADDR_WIDTH-1:0]   m_address;
    logic                    m_write;
    logic [7:0]              m_writedata;
    logic                    m_waitrequest;
    logic                    busy;
    logic                    done;

    // The writer block itself
    modport slave (
        input  in_valid, in_value, in_dp, m_waitrequest,
        output in_ready, m_address, m_write, m_writedata, busy, done
    );

    // Environment: request source and Avalon slave
    modport master (
        output in_valid, in_value, in_dp, m_waitrequest,
        input  in_ready, m_address, m_write, m_writedata, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/seg7_hex_writer.sv
// ============================================================================
// seg7_hex_writer
// Captures a packed hex value and writes one segment pattern per digit over
// Avalon-MM. Optional leading-zero blanking: define SEG7_HEXWR_BLANK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_hex_writer #(
    parameter int SEG7_NUM   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input wire              s_clk,
    input wire              s_reset,
    seg7_hex_writer_if.slave io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_DIGIT = ADDR_WIDTH'(SEG7_NUM - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SEG7_NUM*4-1:0]   value_q;
    logic [SEG7_NUM-1:0]     dp_q;
    logic                    accept;
    logic [3:0]              nibble;
    logic [7:0]              wdata;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign accept = io.in_valid && (state_q == IDLE);

`ifdef SEG7_HEXWR_BLANK_EN
    logic [SEG7_NUM-1:0] blank_q, blank_d;

    // Walk down from the top digit; the run of blanks ends at the first
    // nonzero nibble or set dot. Digit 0 is always shown.
    always_comb begin : blank_mask
        logic run;
        run     = 1'b1;
        blank_d = '0;
        for (int i = SEG7_NUM - 1; i >= 1; i--) begin
            run        = run && (io.in_value[4*i +: 4] == 4'h0) && !io.in_dp[i];
            blank_d[i] = run;
        end
    end

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            blank_q <= '0;
        end else if (accept) begin
            blank_q <= blank_d;
        end
    end
`endif

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                value_q <= io.in_value;
                dp_q    <= io.in_dp;
            end
        end
    end

    // Exit is tested before the increment so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                if (!io.m_waitrequest) begin
                    if (cnt_q == LAST_DIGIT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign nibble = value_q[{cnt_q, 2'b00} +: 4];

    // Write data is decoded from registers only, so it is stable all cycle.
    always_comb begin
        wdata = 8'h00;
        if (state_q == WRITE) begin
            wdata = {dp_q[cnt_q], hex_to_seg(nibble)};
`ifdef SEG7_HEXWR_BLANK_EN
            if (blank_q[cnt_q]) begin
                wdata = 8'h00;
            end
`endif
        end
    end

    assign io.in_ready    = (state_q == IDLE);
    assign io.busy        = (state_q != IDLE);
    assign io.m_write     = (state_q == WRITE);
    assign io.done        = (state_q == DONE);
    assign io.m_address   = cnt_q;
    assign io.m_writedata = wdata;

endmodule

`default_nettype wire
